fft_radix2_seq: RTL and testbench

FFT_RADIX2_SEQ -- requirements
Module: fft_radix2_seq

---
 rtl/fft_pkg.sv | 25 ++
 rtl/fft_twiddle_rom.sv | 33 +++
 rtl/fft_radix2_seq.sv | 206 ++++++++++++++++++++
 tb/tb_fft_radix2_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types, twiddle format constants and bit-reverse helper for fft_radix2_seq
package fft_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_UNLOAD} fft_state_t;

    // Twiddles are signed Q2.(DATA_W-2): two integer bits so +1.0 is representable
    localparam int  TW_INT_W = 2;
    localparam real PI       = 3.14159265358979323846;

    // Butterfly intermediates; 48 bits covers full-precision products for DATA_W up to 23
    localparam int ACC_W = 48;

    typedef struct packed {
        logic signed [ACC_W-1:0] re;
        logic signed [ACC_W-1:0] im;
    } cplx_t;

    // Reverse the low 'bits' bits of x (bits <= 6)
    function automatic logic [5:0] bit_rev(input logic [5:0] x, input int bits);
        logic [5:0] full;
        full = {x[0], x[1], x[2], x[3], x[4], x[5]};
        return full >> (6 - bits);
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// rtl/fft_twiddle_rom.sv - N/2-entry cos/sin twiddle ROM with one-cycle registered read
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic [LOG2N-2:0]  k,
    output logic [DATA_W-1:0] cos_q,
    output logic [DATA_W-1:0] sin_q
);

    localparam int  HALF     = 2 ** (LOG2N - 1);
    localparam real TW_SCALE = 2.0 ** (DATA_W - TW_INT_W);

    logic [DATA_W-1:0] cos_tab [HALF];
    logic [DATA_W-1:0] sin_tab [HALF];

    // Table entries are cos/sin(2*pi*k/N) rounded to nearest; sin is kept positive
    for (genvar i = 0; i < HALF; i++) begin : g_tab
        localparam real ANG = 2.0 * PI * i / (2.0 * HALF);
        assign cos_tab[i] = DATA_W'($rtoi($floor($cos(ANG) * TW_SCALE + 0.5)));
        assign sin_tab[i] = DATA_W'($rtoi($floor($sin(ANG) * TW_SCALE + 0.5)));
    end

    // Registered read so the twiddle lines up with the operand read stage
    always_ff @(posedge clk) begin
        cos_q <= cos_tab[k];
        sin_q <= sin_tab[k];
    end

endmodule

// File: rtl/fft_radix2_seq.sv
// rtl/fft_radix2_seq.sv - sequential in-place radix-2 DIT FFT/IFFT; FFT_STAGE_SCALE_EN enables 1/2 per-stage scaling
module fft_radix2_seq
    import fft_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int LOG2N  = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_imag,
    input  logic              inv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_imag,
    output logic [LOG2N-1:0]  out_index,
    output logic              out_last,
    output logic              busy
);

    localparam int N      = 2 ** LOG2N;
    localparam int HALF   = N / 2;
    localparam int KW     = LOG2N - 1;
    localparam int TW_FRAC = DATA_W - TW_INT_W;
    // Product of a Q.FRAC_W sample and a Q2.TW_FRAC twiddle is realigned to FRAC_W
    localparam int RND_SH = (FRAC_W + TW_FRAC) - FRAC_W;
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) <<< (RND_SH - 1);
    localparam logic signed [ACC_W-1:0] ONE     = ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] x);
        if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    fft_state_t state;
    logic [LOG2N-1:0] load_cnt, cyc, nxt_index, load_addr;
    logic [2:0]       stage;
    logic             inv_q;

    logic signed [DATA_W-1:0] mem_re [N];
    logic signed [DATA_W-1:0] mem_im [N];

    logic             issue, load_we;
    logic [LOG2N-1:0] jw, mask, iss_a, iss_b;
    logic [KW-1:0]    iss_k;
    logic [DATA_W-1:0] tw_cos, tw_sin;

    logic                     p1_v, p2_v;
    logic [LOG2N-1:0]         p1_ia, p1_ib, p2_ia, p2_ib;
    logic signed [DATA_W-1:0] p1_a_re, p1_a_im, p1_b_re, p1_b_im;
    logic signed [DATA_W-1:0] p2_a_re, p2_a_im, p2_b_re, p2_b_im;

    logic signed [ACC_W-1:0] ar, ai, br, bi, cr, ci, sbi, sbr;
    cplx_t bf_wb, bf_sum, bf_dif;

    assign in_ready  = (state == S_IDLE) || (state == S_LOAD);
    assign busy      = (state == S_CALC) || (state == S_UNLOAD);
    assign load_we   = in_valid && in_ready;
    assign load_addr = LOG2N'(bit_rev(6'(load_cnt), LOG2N));
    assign nxt_index = out_index + LOG2N'(1);

    // Butterfly issue addressing: j -> (group, position) within the current stage
    always_comb begin
        issue = (state == S_CALC) && (cyc < LOG2N'(HALF));
        jw    = {1'b0, cyc[LOG2N-2:0]};
        mask  = LOG2N'((1 << stage) - 1);
        iss_a = ((jw >> stage) << (stage + 3'd1)) | (jw & mask);
        iss_b = iss_a | LOG2N'(1 << stage);
        iss_k = KW'((jw & mask) << (LOG2N - 1 - stage));
    end

    fft_twiddle_rom #(.LOG2N(LOG2N), .DATA_W(DATA_W)) u_tw (
        .clk   (CLK),
        .k     (iss_k),
        .cos_q (tw_cos),
        .sin_q (tw_sin)
    );

    // Complex multiply by W (conjugated for inverse), round, add/subtract, optional halve
    always_comb begin
        ar  = ACC_W'(p1_a_re);
        ai  = ACC_W'(p1_a_im);
        br  = ACC_W'(p1_b_re);
        bi  = ACC_W'(p1_b_im);
        cr  = ACC_W'($signed(tw_cos));
        ci  = ACC_W'($signed(tw_sin));
        sbi = ci * bi;
        sbr = ci * br;
        bf_wb.re  = (cr * br + (inv_q ? -sbi : sbi) + RND) >>> RND_SH;
        bf_wb.im  = (cr * bi - (inv_q ? -sbr : sbr) + RND) >>> RND_SH;
        bf_sum.re = ar + bf_wb.re;
        bf_sum.im = ai + bf_wb.im;
        bf_dif.re = ar - bf_wb.re;
        bf_dif.im = ai - bf_wb.im;
`ifdef FFT_STAGE_SCALE_EN
        bf_sum.re = (bf_sum.re + ONE) >>> 1;
        bf_sum.im = (bf_sum.im + ONE) >>> 1;
        bf_dif.re = (bf_dif.re + ONE) >>> 1;
        bf_dif.im = (bf_dif.im + ONE) >>> 1;
`endif
    end

    // Two-stage butterfly pipeline: operand read, then saturated results ready for write-back
    always_ff @(posedge CLK) begin
        p1_ia   <= iss_a;
        p1_ib   <= iss_b;
        p1_a_re <= mem_re[iss_a];
        p1_a_im <= mem_im[iss_a];
        p1_b_re <= mem_re[iss_b];
        p1_b_im <= mem_im[iss_b];
        p2_ia   <= p1_ia;
        p2_ib   <= p1_ib;
        p2_a_re <= sat(bf_sum.re);
        p2_a_im <= sat(bf_sum.im);
        p2_b_re <= sat(bf_dif.re);
        p2_b_im <= sat(bf_dif.im);
    end

    // Sample buffer: bit-reversed load writes and in-place butterfly write-back
    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem_re[load_addr] <= $signed(in_real);
            mem_im[load_addr] <= $signed(in_imag);
        end
        if (p2_v) begin
            mem_re[p2_ia] <= p2_a_re;
            mem_im[p2_ia] <= p2_a_im;
            mem_re[p2_ib] <= p2_b_re;
            mem_im[p2_ib] <= p2_b_im;
        end
    end

    // Control FSM with registered output port
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            load_cnt  <= '0;
            stage     <= '0;
            cyc       <= '0;
            inv_q     <= 1'b0;
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_index <= '0;
            out_real  <= '0;
            out_imag  <= '0;
        end else begin
            p1_v <= issue;
            p2_v <= p1_v;
            case (state)
                S_IDLE: if (in_valid) begin
                    inv_q    <= inv;
                    load_cnt <= LOG2N'(1);
                    state    <= S_LOAD;
                end
                S_LOAD: if (in_valid) begin
                    load_cnt <= load_cnt + LOG2N'(1);
                    if (load_cnt == LOG2N'(N - 1)) begin
                        state <= S_CALC;
                        stage <= '0;
                        cyc   <= '0;
                    end
                end
                S_CALC: begin
                    if (cyc == LOG2N'(HALF + 1)) begin
                        cyc <= '0;
                        if (stage == 3'(LOG2N - 1)) begin
                            state     <= S_UNLOAD;
                            out_valid <= 1'b1;
                            out_last  <= 1'b0;
                            out_index <= '0;
                            out_real  <= mem_re[0];
                            out_imag  <= mem_im[0];
                        end else begin
                            stage <= stage + 3'd1;
                        end
                    end else begin
                        cyc <= cyc + LOG2N'(1);
                    end
                end
                S_UNLOAD: if (out_ready) begin
                    if (out_last) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else begin
                        out_index <= nxt_index;
                        out_real  <= mem_re[nxt_index];
                        out_imag  <= mem_im[nxt_index];
                        out_last  <= (nxt_index == LOG2N'(N - 1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_radix2_seq.sv
// tb/tb_fft_radix2_seq.sv - scoreboard bench for fft_radix2_seq against a floating-point-rounded DIT model
module tb_fft_radix2_seq;

    localparam int    DATA_W   = 16;
    localparam int    FRAC_W   = 8;
    localparam int    LOG2N    = 3;
    localparam int    N        = 2 ** LOG2N;
    localparam int    CALC_CYC = LOG2N * (N / 2 + 2);
    localparam real   TWS      = 16384.0;
    localparam real   M_PI     = 3.14159265358979323846;

    logic              CLK = 0, RST = 1, in_valid = 0, inv = 0, out_ready = 1;
    logic [DATA_W-1:0] in_real = '0, in_imag = '0;
    logic              in_ready, out_valid, out_last, busy;
    logic [DATA_W-1:0] out_real, out_imag;
    logic [LOG2N-1:0]  out_index;

    fft_radix2_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LOG2N(LOG2N)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real),
        .out_imag(out_imag), .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct { int re; int im; int idx; bit last; } exp_t;
    exp_t exp_q[$];
    int   vectors = 0, miscompares = 0;
    int   stim_re[N], stim_im[N], got_re[N], got_im[N];
    int   bp_mode = 0, bp_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_tol(input string name, input longint act, input longint req, input longint tol);
        vectors++;
        if (act > req + tol || act < req - tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d +/- %0d", name, act, req, tol);
        end
    endtask

    function automatic longint rnd_div(input longint x, input real d);
        return longint'($floor(x / d + 0.5));
    endfunction

    function automatic longint clamp(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int brev(input int x);
        int r = 0;
        for (int b = 0; b < LOG2N; b++)
            if ((x & (1 << b)) != 0) r |= 1 << (LOG2N - 1 - b);
        return r;
    endfunction

    // Reference: textbook in-place DIT with per-butterfly rounding and saturation
    task automatic model_push(input bit inv_f);
        longint xr[N], xi[N];
        longint c, s, wr, wi, tr, ti, sr, si, dr, di;
        int a, b, k;
        exp_t e;
        for (int n = 0; n < N; n++) begin
            xr[brev(n)] = stim_re[n];
            xi[brev(n)] = stim_im[n];
        end
        for (int m = 2; m <= N; m *= 2) begin
            for (int g = 0; g < N; g += m) begin
                for (int p = 0; p < m / 2; p++) begin
                    k  = p * N / m;
                    c  = longint'($floor($cos(2.0 * M_PI * k / N) * TWS + 0.5));
                    s  = longint'($floor($sin(2.0 * M_PI * k / N) * TWS + 0.5));
                    wr = c;
                    wi = inv_f ? s : -s;
                    a  = g + p;
                    b  = a + m / 2;
                    tr = rnd_div(wr * xr[b] - wi * xi[b], TWS);
                    ti = rnd_div(wr * xi[b] + wi * xr[b], TWS);
                    sr = xr[a] + tr; si = xi[a] + ti;
                    dr = xr[a] - tr; di = xi[a] - ti;
`ifdef FFT_STAGE_SCALE_EN
                    sr = rnd_div(sr, 2.0); si = rnd_div(si, 2.0);
                    dr = rnd_div(dr, 2.0); di = rnd_div(di, 2.0);
`endif
                    xr[a] = clamp(sr); xi[a] = clamp(si);
                    xr[b] = clamp(dr); xi[b] = clamp(di);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            e.re = int'(xr[n]); e.im = int'(xi[n]); e.idx = n; e.last = (n == N - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_accept();
        bit ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge CLK);
            ok = in_ready;
            @(posedge CLK);
            #1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end
    endtask

    task automatic send_frame(input bit inv_f);
        model_push(inv_f);
        for (int i = 0; i < N; i++) begin
            in_valid = 1;
            in_real  = DATA_W'(stim_re[i]);
            in_imag  = DATA_W'(stim_im[i]);
            inv      = (i == 0) ? inv_f : 1'($urandom_range(0, 1));
            wait_accept();
        end
        in_valid = 0;
        in_real  = DATA_W'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 3000) begin
            @(posedge CLK);
            t++;
        end
        #1;
        if (exp_q.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL drain_timeout: %0d bins outstanding, required 0", exp_q.size());
        end
    endtask

    // Downstream backpressure: 0 always ready, 1 random, 2 repeating 1-0-0-1
    always @(posedge CLK) begin
        #1;
        case (bp_mode)
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin out_ready = (bp_cnt % 4 == 0) || (bp_cnt % 4 == 3); bp_cnt++; end
            default: out_ready = 1;
        endcase
    end

    // Monitor: scoreboard pop on handshake, stall stability, CALC duration
    bit prev_stall = 0, prev_valid = 0;
    int prev_re, prev_im, prev_idx, calc_cnt = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            calc_cnt = 0; prev_stall = 0; prev_valid = 0;
        end else begin
            if (busy && !out_valid) calc_cnt++;
            if (out_valid && !prev_valid) begin
                check("calc_cycles", calc_cnt, CALC_CYC);
                calc_cnt = 0;
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_real", $signed(out_real), prev_re);
                check("stall_imag", $signed(out_imag), prev_im);
                check("stall_index", out_index, prev_idx);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_output: bin %0d with empty scoreboard", out_index);
                end else begin
                    e = exp_q.pop_front();
                    check("bin_index", out_index, e.idx);
                    check("bin_real", $signed(out_real), e.re);
                    check("bin_imag", $signed(out_imag), e.im);
                    check("bin_last", out_last, e.last);
                    got_re[out_index] = $signed(out_real);
                    got_im[out_index] = $signed(out_imag);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_valid = out_valid;
            prev_re    = $signed(out_real);
            prev_im    = $signed(out_imag);
            prev_idx   = out_index;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        repeat (3) @(posedge CLK);
        #1 RST = 0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_out_real", out_real, 0);
        check("rst_out_imag", out_imag, 0);
        check("rst_out_index", out_index, 0);

        // Real ramp 0..7
        for (int i = 0; i < N; i++) begin stim_re[i] = i * 256; stim_im[i] = 0; end
        send_frame(0);
        drain();
`ifdef FFT_STAGE_SCALE_EN
        check_tol("ramp_bin0_real", got_re[0], 896, 1);
        check_tol("ramp_bin4_real", got_re[4], -128, 1);
        check_tol("ramp_bin0_imag", got_im[0], 0, 1);
        check_tol("ramp_bin4_imag", got_im[4], 0, 1);
`else
        check("ramp_bin0_real", got_re[0], 7168);
        check("ramp_bin4_real", got_re[4], -1024);
        check("ramp_bin0_imag", got_im[0], 0);
        check("ramp_bin4_imag", got_im[4], 0);
`endif

        // Inverse transform of 1.0 at sample 1
        for (int i = 0; i < N; i++) begin stim_re[i] = (i == 1) ? 256 : 0; stim_im[i] = 0; end
        send_frame(1);
        drain();
`ifdef FFT_STAGE_SCALE_EN
        check_tol("inv_out1_real", got_re[1], 23, 1);
        check_tol("inv_out1_imag", got_im[1], 23, 1);
`else
        check_tol("inv_out1_real", got_re[1], 181, 1);
        check_tol("inv_out1_imag", got_im[1], 181, 1);
`endif

        // 1-0-0-1 backpressure during unload
        for (int i = 0; i < N; i++) begin
            stim_re[i] = int'($signed(16'($urandom))) >>> 2;
            stim_im[i] = int'($signed(16'($urandom))) >>> 2;
        end
        bp_cnt = 0; bp_mode = 2;
        send_frame(0);
        drain();

        // Random frames: random direction, magnitude and backpressure
        for (int f = 0; f < 8; f++) begin
            int sh;
            sh = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                stim_re[i] = int'($signed(16'($urandom))) >>> sh;
                stim_im[i] = int'($signed(16'($urandom))) >>> sh;
            end
            bp_mode = $urandom_range(0, 1);
            send_frame(1'($urandom_range(0, 1)));
            drain();
        end
        bp_mode = 0;

        // Reset in the middle of CALC
        for (int i = 0; i < N; i++) begin stim_re[i] = i * 100; stim_im[i] = -i * 50; end
        send_frame(0);
        t = 0;
        while (!busy && t < 50) begin @(posedge CLK); #1; t++; end
        repeat (5) @(posedge CLK);
        #1 RST = 1;
        @(posedge CLK);
        #1 RST = 0;
        exp_q.delete();
        check("midcalc_rst_in_ready", in_ready, 1);
        check("midcalc_rst_out_valid", out_valid, 0);
        check("midcalc_rst_busy", busy, 0);
        for (int i = 0; i < N; i++) begin
            stim_re[i] = int'($signed(16'($urandom))) >>> 1;
            stim_im[i] = int'($signed(16'($urandom))) >>> 1;
        end
        send_frame(0);
        drain();

        repeat (3) @(posedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
